// File: rtl/gtp_tx_pkg.sv
// Shared types and K-character framing constants for the GTP transmit sequencer.
package gtp_tx_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned K_W    = 8;
    localparam int unsigned PRBS_W = 48;
    localparam int unsigned HDR_W  = 16;
    localparam int unsigned BOND_W = 8;

    typedef enum logic [1:0] {
        ST_WAIT_GTP = 2'd0,
        ST_BOND     = 2'd1,
        ST_START    = 2'd2,
        ST_RUN      = 2'd3
    } tx_state_e;

    localparam logic [DATA_W-1:0] BOND_SEQ  = 64'h1CFE_FBDC_0000_0000;
    localparam logic [K_W-1:0]    BOND_K    = 8'hF0;
    localparam logic [DATA_W-1:0] IDLE_WORD = 64'h0000_0000_FCFC_FCFC;
    localparam logic [K_W-1:0]    IDLE_K    = 8'hFF;
    localparam logic [HDR_W-1:0]  COMMA_HDR = 16'hBC50;
    localparam logic [K_W-1:0]    DATA_K    = 8'h03;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [K_W-1:0]    k;
    } tx_word_t;

endpackage

// File: rtl/gtp_tx_frame_mux.sv
// Registered frame-word selector: picks idle, bond, comma-idle or PRBS payload
// from the effective sequencer state, with optional single-bit error injection.
module gtp_tx_frame_mux
    import gtp_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  tx_state_e         state_i,
    input  logic              bond_stb_i,
    input  logic              inject_i,
    input  logic [PRBS_W-1:0] prbs_data_i,
    output tx_word_t          word_o
);

    tx_word_t word_d;
    tx_word_t word_q;

    always_comb begin
        word_d = '0;
        case (state_i)
            ST_BOND: begin
                if (bond_stb_i) begin
                    word_d.data = BOND_SEQ;
                    word_d.k    = BOND_K;
                end
            end
            ST_START: begin
                word_d.data = IDLE_WORD;
                word_d.k    = IDLE_K;
            end
            ST_RUN: begin
                // Injection flips the LSB of the PRBS field (bit 16 of the word).
                word_d.data     = {prbs_data_i, COMMA_HDR};
                word_d.data[16] = prbs_data_i[0] ^ inject_i;
                word_d.k        = DATA_K;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/gtp_tx_sequencer.sv
// GTP dual-TX bring-up sequencer: waits for tile reset-done, bonds, releases
// PRBS through a comma window, then frames PRBS data with error-inject/rebond.
module gtp_tx_sequencer
    import gtp_tx_pkg::*;
#(
    parameter int unsigned BOND_SPACING_LOG2 = 5,
    parameter int unsigned BOND_COUNT        = 255,
    parameter int unsigned START_TIMEOUT     = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        gtp_reset_done,
    input  logic              rebond_req,
    input  logic [PRBS_W-1:0] prbs_data,
    input  logic              prbs_strt_ltncy,
    input  logic              inj_err_req,
    output logic              inj_err_ack,
    output logic              prbs_rst,
    output logic [DATA_W-1:0] tx_data,
    output logic [K_W-1:0]    tx_iskchar,
    output logic [1:0]        state,
    output logic              bonding_done,
    output logic              link_ready,
    output logic              start_timeout
);

    localparam int unsigned SP_W     = BOND_SPACING_LOG2;
    localparam int unsigned TMO_BITS = $clog2(START_TIMEOUT + 1);
    localparam int unsigned TMO_W    = (TMO_BITS > 10) ? TMO_BITS : 10;

    tx_state_e         state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [BOND_W-1:0] bond_q, bond_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              sto_q, sto_d;
    logic              served_q, served_d;
    logic              ack_q, prbs_rst_q, bdone_q, lready_q;

    logic              gtp_ok;
    logic              bond_stb;
    logic              inject_c;
    tx_state_e         mux_state;
    tx_word_t          word;

    assign gtp_ok    = &gtp_reset_done;
    assign bond_stb  = (sp_q == {SP_W{1'b1}});
    // Losing a tile overrides the current state for the word being registered.
    assign mux_state = gtp_ok ? state_q : ST_WAIT_GTP;
    assign inject_c  = (mux_state == ST_RUN) && inj_err_req && !served_q;
    // A served request stays blocked until the requester drops it for a cycle.
    assign served_d  = inj_err_req && (served_q || inject_c);

    always_comb begin
        state_d = state_q;
        sp_d    = '0;
        bond_d  = bond_q;
        tmo_d   = '0;
        sto_d   = sto_q;
        case (state_q)
            ST_WAIT_GTP: begin
                if (gtp_ok) begin
                    state_d = ST_BOND;
                    bond_d  = '0;
                end
            end
            ST_BOND: begin
                sp_d = sp_q + SP_W'(1);
                if (bond_stb) begin
                    bond_d = bond_q + BOND_W'(1);
                    if (bond_q == BOND_W'(BOND_COUNT - 1)) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (!prbs_strt_ltncy) begin
                    state_d = ST_RUN;
                end else if (tmo_d == TMO_W'(START_TIMEOUT)) begin
                    state_d = ST_BOND;
                    sto_d   = 1'b1;
                    bond_d  = '0;
                end
            end
            ST_RUN: begin
                if (rebond_req) begin
                    state_d = ST_BOND;
                    bond_d  = '0;
                end
            end
        endcase
        if (!gtp_ok) begin
            state_d = ST_WAIT_GTP;
            sp_d    = '0;
            bond_d  = '0;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_WAIT_GTP;
            sp_q       <= '0;
            bond_q     <= '0;
            tmo_q      <= '0;
            sto_q      <= 1'b0;
            served_q   <= 1'b0;
            ack_q      <= 1'b0;
            prbs_rst_q <= 1'b1;
            bdone_q    <= 1'b0;
            lready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            bond_q     <= bond_d;
            tmo_q      <= tmo_d;
            sto_q      <= sto_d;
            served_q   <= served_d;
            ack_q      <= inject_c;
            prbs_rst_q <= !((state_d == ST_START) || (state_d == ST_RUN));
            bdone_q    <= (state_d == ST_START) || (state_d == ST_RUN);
            lready_q   <= (state_d == ST_RUN);
        end
    end

    gtp_tx_frame_mux u_frame_mux (
        .clk         (clock),
        .rst_n       (reset),
        .state_i     (mux_state),
        .bond_stb_i  (bond_stb),
        .inject_i    (inject_c),
        .prbs_data_i (prbs_data),
        .word_o      (word)
    );

    assign tx_data       = word.data;
    assign tx_iskchar    = word.k;
    assign state         = state_q;
    assign inj_err_ack   = ack_q;
    assign prbs_rst      = prbs_rst_q;
    assign bonding_done  = bdone_q;
    assign link_ready    = lready_q;
    assign start_timeout = sto_q;

endmodule

// File: tb/tb_gtp_tx_sequencer.sv
// Scoreboard bench for gtp_tx_sequencer: a phase/cycle-count reference model
// predicts every registered output word; a negedge monitor compares.
`timescale 1ns/1ps
module tb_gtp_tx_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  gtp_reset_done = 2'b00;
    logic        rebond_req = 1'b0;
    logic [47:0] prbs_data = '0;
    logic        prbs_strt_ltncy = 1'b1;
    logic        inj_err_req = 1'b0;
    logic        inj_err_ack, prbs_rst, bonding_done, link_ready, start_timeout;
    logic [63:0] tx_data;
    logic [7:0]  tx_iskchar;
    logic [1:0]  state;

    gtp_tx_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .gtp_reset_done  (gtp_reset_done),
        .rebond_req      (rebond_req),
        .prbs_data       (prbs_data),
        .prbs_strt_ltncy (prbs_strt_ltncy),
        .inj_err_req     (inj_err_req),
        .inj_err_ack     (inj_err_ack),
        .prbs_rst        (prbs_rst),
        .tx_data         (tx_data),
        .tx_iskchar      (tx_iskchar),
        .state           (state),
        .bonding_done    (bonding_done),
        .link_ready      (link_ready),
        .start_timeout   (start_timeout)
    );

    always #12.5 clock = ~clock;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  k;
        logic [1:0]  st;
        logic        prst;
        logic        bd;
        logic        lr;
        logic        sto;
        logic        ack;
    } obs_t;

    obs_t exp_q[$];
    obs_t e_w, a_w;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wait_fail_cnt = 0;
    int   wait_fail_seen = 0;

    // Reference model: phase 0..3 plus plain cycle/frame tallies.
    int m_phase = 0, m_bond_cyc = 0, m_frames = 0, m_start_cyc = 0;
    bit m_served = 0, m_sticky = 0;

    function automatic obs_t reset_obs();
        obs_t e;
        e = '0;
        e.prst = 1'b1;
        return e;
    endfunction

    function automatic obs_t model_step();
        obs_t e;
        int   nxt;
        bit   inj;
        e   = '0;
        inj = 1'b0;
        nxt = m_phase;
        if (!reset) begin
            m_phase = 0; m_bond_cyc = 0; m_frames = 0; m_start_cyc = 0;
            m_served = 0; m_sticky = 0;
            return reset_obs();
        end
        if (gtp_reset_done != 2'b11) begin
            nxt = 0;
        end else begin
            case (m_phase)
                0: begin
                    nxt = 1; m_bond_cyc = 0; m_frames = 0;
                end
                1: begin
                    m_bond_cyc++;
                    if (m_bond_cyc % 32 == 0) begin
                        e.data = 64'h1CFEFBDC00000000;
                        e.k    = 8'hF0;
                        m_frames++;
                        if (m_frames == 255) begin
                            nxt = 2; m_start_cyc = 0;
                        end
                    end
                end
                2: begin
                    e.data = 64'h00000000FCFCFCFC;
                    e.k    = 8'hFF;
                    m_start_cyc++;
                    if (!prbs_strt_ltncy) nxt = 3;
                    else if (m_start_cyc == 1023) begin
                        m_sticky = 1; nxt = 1; m_bond_cyc = 0; m_frames = 0;
                    end
                end
                default: begin
                    inj    = inj_err_req && !m_served;
                    e.data = {prbs_data, 16'hBC50};
                    if (inj) e.data[16] = ~e.data[16];
                    e.k = 8'h03;
                    if (rebond_req) begin
                        nxt = 1; m_bond_cyc = 0; m_frames = 0;
                    end
                end
            endcase
        end
        m_served = inj_err_req && (m_served || inj);
        m_phase  = nxt;
        e.st   = 2'(nxt);
        e.prst = (nxt < 2);
        e.bd   = (nxt >= 2);
        e.lr   = (nxt == 3);
        e.sto  = m_sticky;
        e.ack  = inj;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        exp_q.push_back(model_step());
        #1;
        prbs_data = {16'($urandom), $urandom};
    endtask

    task automatic wait_phase(input int ph, input int budget, input bit rnd_req);
        int n;
        n = 0;
        while (m_phase != ph && n < budget) begin
            if (rnd_req) inj_err_req = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (m_phase != ph) begin
            $display("FAIL wait_phase: phase %0d not reached within %0d cycles (at %0d)",
                     ph, budget, m_phase);
            wait_fail_cnt++;
        end
    endtask

    task automatic run_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 3) == 0) inj_err_req = ~inj_err_req;
            prbs_strt_ltncy = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    // Monitor: every cycle with an expectation queued is compared.
    always @(negedge clock) begin
        if (wait_fail_cnt != wait_fail_seen) begin
            wait_fail_seen = wait_fail_seen + 1;
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL phase_budget: got expired wait, required reach target phase");
        end
        if (exp_q.size() > 0) begin
            e_w = exp_q.pop_front();
            a_w = {tx_data, tx_iskchar, state, prbs_rst, bonding_done, link_ready,
                   start_timeout, inj_err_ack};
            n_cmp = n_cmp + 1;
            if (a_w !== e_w) begin
                n_bad = n_bad + 1;
                $display("FAIL out_word @%0t: got data=%h k=%h st=%0d prst=%b bd=%b lr=%b sto=%b ack=%b / exp data=%h k=%h st=%0d prst=%b bd=%b lr=%b sto=%b ack=%b",
                         $time, a_w.data, a_w.k, a_w.st, a_w.prst, a_w.bd, a_w.lr, a_w.sto, a_w.ack,
                         e_w.data, e_w.k, e_w.st, e_w.prst, e_w.bd, e_w.lr, e_w.sto, e_w.ack);
            end
        end
    end

    initial begin
        #2500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        gtp_reset_done = 2'b11;

        // First burst, with injection requests left pending outside RUN.
        wait_phase(2, 9000, 1'b1);
        prbs_strt_ltncy = 1'b1;
        inj_err_req = 1'b1;
        repeat (5) tick();
        prbs_strt_ltncy = 1'b0;
        tick();
        repeat (2) tick();
        inj_err_req = 1'b0;
        tick();
        run_random(300);

        // Three-cycle request hold: a single ack.
        inj_err_req = 1'b0; tick();
        inj_err_req = 1'b1; repeat (3) tick();
        inj_err_req = 1'b0; repeat (2) tick();

        // Rebond together with an injection request.
        rebond_req = 1'b1; inj_err_req = 1'b1; tick();
        rebond_req = 1'b0; inj_err_req = 1'b0; tick();

        // Tile loss mid-BOND, then a full burst after restore.
        repeat (1000) tick();
        gtp_reset_done = 2'b01; repeat (3) tick();
        gtp_reset_done = 2'b11;
        wait_phase(2, 9000, 1'b0);
        prbs_strt_ltncy = 1'b0; tick();
        run_random(100);

        // Tile loss in RUN coinciding with both requests.
        prbs_strt_ltncy = 1'b1;
        gtp_reset_done = 2'b01; rebond_req = 1'b1; inj_err_req = 1'b1; tick();
        rebond_req = 1'b0; inj_err_req = 1'b0; repeat (2) tick();
        gtp_reset_done = 2'b11;

        // START timeout returns to BOND and sets the sticky flag.
        wait_phase(2, 9000, 1'b0);
        prbs_strt_ltncy = 1'b1;
        wait_phase(1, 1100, 1'b0);
        wait_phase(2, 9000, 1'b0);
        prbs_strt_ltncy = 1'b0; tick();
        run_random(50);

        // Asynchronous reset between clock edges.
        #4;
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(reset_obs());
        @(negedge clock);
        repeat (2) tick();
        reset = 1'b1;
        gtp_reset_done = 2'b11;
        repeat (40) tick();

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
